// File: rtl/montgomery_reduce_stream.sv
`default_nettype none
// ============================================================================
// montgomery_reduce_stream : pipelined r = x * 2^-k mod m, valid/ready, tagged
// Optional: MONT_REDUCE_RANGE_CHECK_EN flags x >= m*2^k on out_err_o
// Revision: 1.0
// ============================================================================
module montgomery_reduce_stream #(
    parameter int WIDTH      = 64,
    parameter int MUL_STAGES = 3,
    parameter int TAG_W      = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cfg_we_i,
    input  logic [WIDTH-1:0]           cfg_m_i,
    input  logic [WIDTH-1:0]           cfg_minv_i,
    input  logic [$clog2(WIDTH+1)-1:0] cfg_k_i,
    output logic                       cfg_err_o,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [2*WIDTH-1:0]         in_x_i,
    input  logic [TAG_W-1:0]           in_tag_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           out_r_o,
    output logic [TAG_W-1:0]           out_tag_o,
    output logic                       out_err_o,
    output logic                       idle_o
);
    localparam int KW  = $clog2(WIDTH+1);
    localparam int LAT = 2*MUL_STAGES + 2;
    localparam int DLY = 2*MUL_STAGES + 1;
    localparam int CW  = $clog2(LAT+1);

    typedef enum logic [0:0] {ST_UNCFG = 1'b0, ST_RUN = 1'b1} state_t;

    state_t             r_state, w_state_next;
    logic [WIDTH-1:0]   r_m, r_minv;
    logic [KW-1:0]      r_k;
    logic [CW-1:0]      r_cnt;
    logic               w_adv, w_accept, w_out_fire, w_cfg_load, w_cfg_reject;
    logic [WIDTH-1:0]   w_mask, w_q_in, w_r;
    logic [2*WIDTH-1:0] w_p_in;
    logic [2*WIDTH:0]   w_sum;
    logic [WIDTH:0]     w_t;

    logic               r_vld [DLY];
    logic [2*WIDTH-1:0] r_x   [DLY];
    logic [TAG_W-1:0]   r_tag [DLY];
    logic [WIDTH-1:0]   r_q   [MUL_STAGES];
    logic [2*WIDTH-1:0] r_p   [MUL_STAGES];

    assign idle_o     = (r_state == ST_RUN) && (r_cnt == '0);
    assign w_adv      = !(out_valid_o && !out_ready_i);
    assign in_ready_o = (r_state == ST_RUN) && w_adv && !cfg_we_i;
    assign w_accept   = in_valid_i && in_ready_o;
    assign w_out_fire = out_valid_o && out_ready_i;

    always_comb begin
        w_state_next = r_state;
        w_cfg_load   = 1'b0;
        w_cfg_reject = 1'b0;
        case (r_state)
            ST_UNCFG: begin
                if (cfg_we_i) begin
                    w_cfg_load   = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cfg_we_i) begin
                    w_cfg_load   = idle_o;
                    w_cfg_reject = !idle_o;
                end
            end
            default: w_state_next = ST_UNCFG;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_UNCFG;
            r_m       <= '0;
            r_minv    <= '0;
            r_k       <= '0;
            cfg_err_o <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_next;
            cfg_err_o <= w_cfg_reject;
            if (w_cfg_load) begin
                r_m    <= cfg_m_i;
                r_minv <= cfg_minv_i;
                r_k    <= cfg_k_i;
            end
            case ({w_accept, w_out_fire})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // k == WIDTH selects the all-ones mask so the shift never reaches WIDTH
    assign w_mask = (r_k >= KW'(WIDTH)) ? '1 : ((WIDTH'(1) << r_k) - WIDTH'(1));
    assign w_q_in = ((r_x[0][WIDTH-1:0] & w_mask) * r_minv) & w_mask;
    assign w_p_in = {{WIDTH{1'b0}}, r_q[MUL_STAGES-1]} * {{WIDTH{1'b0}}, r_m};
    assign w_sum  = {1'b0, r_x[DLY-1]} + {1'b0, r_p[MUL_STAGES-1]};
    assign w_t    = (WIDTH+1)'(w_sum >> r_k);
    assign w_r    = (w_t >= {1'b0, r_m}) ? WIDTH'(w_t - {1'b0, r_m}) : w_t[WIDTH-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DLY; i++) begin
                r_vld[i] <= 1'b0;
                r_x[i]   <= '0;
                r_tag[i] <= '0;
            end
            for (int i = 0; i < MUL_STAGES; i++) begin
                r_q[i] <= '0;
                r_p[i] <= '0;
            end
            out_valid_o <= 1'b0;
            out_r_o     <= '0;
            out_tag_o   <= '0;
        end else if (w_adv) begin
            r_vld[0] <= w_accept;
            if (w_accept) begin
                r_x[0]   <= in_x_i;
                r_tag[0] <= in_tag_i;
            end
            for (int i = 1; i < DLY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_x[i]   <= r_x[i-1];
                r_tag[i] <= r_tag[i-1];
            end
            r_q[0] <= w_q_in;
            r_p[0] <= w_p_in;
            for (int i = 1; i < MUL_STAGES; i++) begin
                r_q[i] <= r_q[i-1];
                r_p[i] <= r_p[i-1];
            end
            out_valid_o <= r_vld[DLY-1];
            if (r_vld[DLY-1]) begin
                out_r_o   <= w_r;
                out_tag_o <= r_tag[DLY-1];
            end
        end
    end

`ifdef MONT_REDUCE_RANGE_CHECK_EN
    logic               r_err [DLY];
    logic [2*WIDTH-1:0] w_lim;

    // m < 2^k <= 2^WIDTH, so m*2^k always fits in 2*WIDTH bits
    assign w_lim = {{WIDTH{1'b0}}, r_m} << r_k;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DLY; i++) begin
                r_err[i] <= 1'b0;
            end
            out_err_o <= 1'b0;
        end else if (w_adv) begin
            r_err[0] <= w_accept && (in_x_i >= w_lim);
            for (int i = 1; i < DLY; i++) begin
                r_err[i] <= r_err[i-1];
            end
            if (r_vld[DLY-1]) begin
                out_err_o <= r_err[DLY-1];
            end
        end
    end
`else
    assign out_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_montgomery_reduce_stream.sv
`default_nettype none
// tb_montgomery_reduce_stream : table vectors, directed corner sequences and
// random streams checked against an arithmetic model of x * 2^-k mod m.
module tb_montgomery_reduce_stream;
    localparam int W  = 64;
    localparam int MS = 3;
    localparam int TW = 8;
    localparam int KW = $clog2(W+1);
    localparam int L  = 2*MS + 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_we = 1'b0;
    logic [W-1:0]    cfg_m = '0;
    logic [W-1:0]    cfg_minv = '0;
    logic [KW-1:0]   cfg_k = '0;
    logic            cfg_err;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2*W-1:0]  in_x = '0;
    logic [TW-1:0]   in_tag = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [W-1:0]    out_r;
    logic [TW-1:0]   out_tag;
    logic            out_err;
    logic            idle;

    montgomery_reduce_stream #(.WIDTH(W), .MUL_STAGES(MS), .TAG_W(TW)) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_we_i(cfg_we), .cfg_m_i(cfg_m), .cfg_minv_i(cfg_minv), .cfg_k_i(cfg_k),
        .cfg_err_o(cfg_err),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_x_i(in_x), .in_tag_i(in_tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_r_o(out_r),
        .out_tag_o(out_tag), .out_err_o(out_err), .idle_o(idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [TW-1:0] tag;
        logic [W-1:0]  r;
        logic          oor;
    } exp_t;

    typedef struct {
        logic [W-1:0]   m;
        logic [W-1:0]   minv;
        int             k;
        logic [2*W-1:0] x;
        logic [W-1:0]   exp;
    } vec_t;

    exp_t           q[$];
    exp_t           mon_e;
    logic [W-1:0]   mdl_m = '0;
    int             mdl_k = 0;
    logic           mon_en = 1'b0;
    logic           prev_stall = 1'b0;
    logic [W-1:0]   held_r;
    logic [TW-1:0]  held_tag;
    logic           held_err;
    vec_t           tbl[7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // x * 2^-k mod m: reduce, then halve k times modulo the odd m
    function automatic logic [W-1:0] mont_ref(input logic [2*W-1:0] x, input logic [W-1:0] m, input int k);
        logic [W+1:0] v;
        v = (W+2)'(x % {{W{1'b0}}, m});
        for (int i = 0; i < k; i++) begin
            if (v[0]) v = v + {2'b00, m};
            v = v >> 1;
        end
        return v[W-1:0];
    endfunction

    function automatic logic [2*W-1:0] lim_of(input logic [W-1:0] m, input int k);
        return {{W{1'b0}}, m} << k;
    endfunction

    function automatic logic [W-1:0] calc_minv(input logic [W-1:0] m, input int k);
        logic [W-1:0] inv, mask;
        inv = m;
        for (int i = 0; i < 6; i++) inv = inv * (64'd2 - m * inv);
        mask = (k >= W) ? '1 : ((64'd1 << k) - 64'd1);
        return (64'd0 - inv) & mask;
    endfunction

    function automatic logic [2*W-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    always @(negedge clk) begin
        #2;
        if (!mon_en) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", {out_err, out_tag, out_r}, {held_err, held_tag, held_r});
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", in_ready, 1'b0);
                prev_stall = 1'b1;
                held_r = out_r; held_tag = out_tag; held_err = out_err;
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output r=%0h tag=%0h required=none", out_r, out_tag);
                end else begin
                    mon_e = q.pop_front();
                    chk("out_tag", out_tag, mon_e.tag);
                    if (!mon_e.oor) chk("out_r", out_r, mon_e.r);
`ifdef MONT_REDUCE_RANGE_CHECK_EN
                    chk("out_err", out_err, mon_e.oor);
`else
                    chk("out_err", out_err, 1'b0);
`endif
                end
            end
            if (in_valid && in_ready) begin
                mon_e.tag = in_tag;
                mon_e.r   = mont_ref(in_x, mdl_m, mdl_k);
                mon_e.oor = (in_x >= lim_of(mdl_m, mdl_k));
                q.push_back(mon_e);
            end
        end
    end

    task automatic cfg_write(input logic [W-1:0] m, input logic [W-1:0] minv, input int k);
        @(negedge clk);
        cfg_we = 1'b1; cfg_m = m; cfg_minv = minv; cfg_k = KW'(k);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk); #3; n++;
        end while (!idle && n < 500);
        if (!idle) begin
            checks++; errors++;
            $display("FAIL idle_timeout idle=%0b required=1", idle);
        end
    endtask

    task automatic send_one(input logic [2*W-1:0] x, input logic [TW-1:0] tag);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_x = x; in_tag = tag;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_stream(input int n, input bit rand_rdy, input logic [TW-1:0] tag_base);
        logic [2*W-1:0] lim, cur_x;
        int sent, cyc, first_ov, last_ov, n_ov, send_cyc;
        lim = lim_of(mdl_m, mdl_k);
        sent = 0; cyc = 0; first_ov = -1; last_ov = -1; n_ov = 0; send_cyc = 0;
        cur_x = rnd128() % lim;
        while ((sent < n || !idle) && cyc < 4000) begin
            @(negedge clk);
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = (sent < n);
            in_x      = cur_x;
            in_tag    = tag_base + TW'(sent);
            #1;
            if (out_valid && out_ready) begin
                if (first_ov < 0) first_ov = cyc;
                last_ov = cyc;
                n_ov++;
            end
            if (in_valid && in_ready) begin
                sent++;
                cur_x = rnd128() % lim;
                if (sent == n) send_cyc = cyc + 1;
            end
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_done", {sent == n, idle}, 2'b11);
        chk("stream_count", n_ov, n);
        if (!rand_rdy) begin
            chk("stream_rate", send_cyc, n);
            chk("stream_contig", last_ov - first_ov, n - 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]   m_big, m_r;
        logic [2*W-1:0] lim17;
        int             k_r;

        m_big = {1'b1, 31'($urandom()), $urandom()} | 64'd1;
        tbl[0] = '{m: 64'd17, minv: 64'd15, k: 5, x: 128'd100, exp: 64'd1};
        tbl[1] = '{m: 64'd17, minv: 64'd15, k: 5, x: 128'd543, exp: 64'd9};
        tbl[2] = '{m: 64'd17, minv: 64'd15, k: 5, x: 128'd0,   exp: 64'd0};
        tbl[3] = '{m: 64'd17, minv: 64'd15, k: 5, x: 128'd1,   exp: 64'd8};
        tbl[4] = '{m: 64'd7,  minv: 64'd1,  k: 3, x: 128'd10,  exp: 64'd3};
        tbl[5] = '{m: 64'd7,  minv: 64'd1,  k: 3, x: 128'd55,  exp: 64'd6};
        tbl[6] = '{m: m_big, minv: calc_minv(m_big, 64), k: 64,
                   x: lim_of(m_big, 64) - 128'd1, exp: '0};
        tbl[6].exp = mont_ref(tbl[6].x, m_big, 64);

        // reset values while held in reset
        repeat (3) @(negedge clk);
        #3;
        chk("rst_outputs", {out_valid, out_r, out_tag, out_err, cfg_err, idle, in_ready}, '0);
        rst = 1'b0;
        mon_en = 1'b1;

        // unconfigured: operands refused
        @(negedge clk);
        in_valid = 1'b1; in_x = 128'd5;
        #1 chk("uncfg_in_ready", in_ready, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;

        // table vectors with exact latency
        for (int i = 0; i < 7; i++) begin
            if (i == 0 || tbl[i].m != mdl_m || tbl[i].k != mdl_k) begin
                if (i != 0) wait_idle();
                cfg_write(tbl[i].m, tbl[i].minv, tbl[i].k);
                mdl_m = tbl[i].m; mdl_k = tbl[i].k;
            end
            @(negedge clk);
            in_valid = 1'b1; in_x = tbl[i].x; in_tag = TW'(i + 1);
            #1 chk("tbl_in_ready", in_ready, 1'b1);
            for (int c = 1; c <= L; c++) begin
                @(negedge clk);
                in_valid = 1'b0;
                #3;
                if (c == L-1) chk("tbl_latency_early", out_valid, 1'b0);
                if (c == L) begin
                    chk("tbl_latency", out_valid, 1'b1);
                    chk("tbl_result", out_r, tbl[i].exp);
                    chk("tbl_lt_m", out_r < tbl[i].m, 1'b1);
                end
            end
        end

        // back-to-back stream, full-width modulus
        wait_idle();
        m_r = rnd128()[63:0] | 64'h8000_0000_0000_0001;
        cfg_write(m_r, calc_minv(m_r, 64), 64);
        mdl_m = m_r; mdl_k = 64;
        run_stream(64, 1'b0, 8'h00);

        // stream with random backpressure and random k
        wait_idle();
        k_r = $urandom_range(2, 63);
        m_r = (rnd128()[63:0] & ((64'd1 << k_r) - 64'd1)) | 64'd1;
        cfg_write(m_r, calc_minv(m_r, k_r), k_r);
        mdl_m = m_r; mdl_k = k_r;
        run_stream(64, 1'b1, 8'h40);

        // config and operand together while idle: config wins
        wait_idle();
        @(negedge clk);
        cfg_we = 1'b1; cfg_m = 64'd17; cfg_minv = 64'd15; cfg_k = KW'(5);
        in_valid = 1'b1; in_x = 128'd100; in_tag = 8'h55;
        #1 chk("cfg_beats_in", in_ready, 1'b0);
        mdl_m = 64'd17; mdl_k = 5;
        @(negedge clk);
        cfg_we = 1'b0;
        #1 chk("post_cfg_accept", in_ready, 1'b1);
        @(negedge clk);
        in_x = 128'd543; in_tag = 8'h56;
        #1 chk("inflight_accept2", in_ready, 1'b1);
        @(negedge clk);
        in_x = 128'd1; in_tag = 8'h57;
        #1 chk("inflight_accept3", in_ready, 1'b1);
        // write while three operands are in flight is rejected
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_m = 64'd7; cfg_minv = 64'd1; cfg_k = KW'(3);
        #1 chk("busy_cfg_in_ready", in_ready, 1'b0);
        @(negedge clk);
        cfg_we = 1'b0;
        #3 chk("cfg_err_pulse", cfg_err, 1'b1);
        @(negedge clk);
        #3 chk("cfg_err_once", cfg_err, 1'b0);
        wait_idle();
        cfg_write(64'd7, 64'd1, 3);
        mdl_m = 64'd7; mdl_k = 3;
        #3 chk("cfg_ok_no_err", cfg_err, 1'b0);
        send_one(128'd55, 8'h60);
        send_one(128'd10, 8'h61);

        // range boundary
        wait_idle();
        cfg_write(64'd17, 64'd15, 5);
        mdl_m = 64'd17; mdl_k = 5;
        send_one(128'd544, 8'h70);
        send_one(128'd543, 8'h71);
        wait_idle();

        // reset with four operands in flight, output stalled
        lim17 = lim_of(64'd17, 5);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_x = rnd128() % lim17; in_tag = TW'(8'hA0 + i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (L+1) @(negedge clk);
        #1 chk("pre_reset_valid", out_valid, 1'b1);
        mon_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", {out_err, out_tag, out_r}, '0);
        chk("rst_idle_ready", {idle, in_ready, cfg_err}, 3'b000);
        q.delete();
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1; mon_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_x = rnd128() % lim17;
            #1;
            if (i % 5 == 0) begin
                chk("uncfg_after_rst", in_ready, 1'b0);
                chk("no_stale_out", out_valid, 1'b0);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        #3;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
